// File: rtl/fetch_if.sv
// Bundle between the fetch unit and its surroundings: PC control, instruction
// memory port, fetch results and debug visibility of the FSM.
interface fetch_if;
    logic        fetch_req;
    logic        pc_write;
    logic [31:0] next_pc;
    logic [31:0] imem_address;
    logic [31:0] imem_data_out;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic [31:0] fetch_count;
    logic        fault;
    // Debug: FSM state (0 IDLE, 1 ADDR, 2 DATA) and whether pc lies in the imem window
    logic [1:0]  state_dbg;
    logic        pc_in_window;

    modport master (
        output fetch_req, pc_write, next_pc, imem_data_out,
        input  imem_address, pc, ir, ir_valid, busy, fetch_count, fault,
               state_dbg, pc_in_window
    );

    modport slave (
        input  fetch_req, pc_write, next_pc, imem_data_out,
        output imem_address, pc, ir, ir_valid, busy, fetch_count, fault,
               state_dbg, pc_in_window
    );
endinterface

// File: rtl/fetch_unit.sv
// Three-state instruction fetch unit against a synchronous instruction memory.
// Optional address checking is enabled with macro FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00001000,
    parameter logic [31:0] IMEM_BASE  = 32'h00001000,
    parameter logic [31:0] IMEM_BYTES = 32'h00001000
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);

    // Handshake: fetch_req is sampled only in IDLE; while busy it is dropped,
    // never queued. ir_valid pulses for one cycle after ir is written.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic [31:0] r_fetch_count;
    logic        r_fault;
    logic        w_accept;
    logic        w_reject;
    logic        w_addr_ok;
    logic        w_in_window;
    logic [31:0] w_pc_aligned;

    assign w_pc_aligned = {r_pc[31:2], 2'b00};

    // 33-bit compare so a window ending at 4 GiB does not wrap
    assign w_in_window = ({1'b0, r_pc} >= {1'b0, IMEM_BASE}) &&
                         ({1'b0, r_pc} <  ({1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES}));

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_addr_ok = (r_pc[1:0] == 2'b00) && w_in_window;
`else
    assign w_addr_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fetch_req) begin
                    if (w_addr_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ADDR;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ADDR:    w_state_nxt = DATA;
            DATA:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_addr  <= RESET_PC;
            r_ir          <= NOP;
            r_ir_valid    <= 1'b0;
            r_fetch_count <= 32'd0;
            r_fault       <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            r_fault    <= w_reject;
            // fetch_addr is captured from the old pc, so a same-edge pc_write
            // only affects later fetches
            if (bus.pc_write) begin
                r_pc <= bus.next_pc;
            end
            if (w_accept) begin
                r_fetch_addr <= w_pc_aligned;
            end
            if (r_state == DATA) begin
                r_ir          <= bus.imem_data_out;
                r_ir_valid    <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.imem_address = (r_state == IDLE) ? w_pc_aligned : r_fetch_addr;
    assign bus.pc           = r_pc;
    assign bus.ir           = r_ir;
    assign bus.ir_valid     = r_ir_valid;
    assign bus.busy         = (r_state != IDLE);
    assign bus.fetch_count  = r_fetch_count;
    assign bus.fault        = r_fault;
    assign bus.state_dbg    = r_state;
    assign bus.pc_in_window = w_in_window;

endmodule
